key_controller: RTL and testbench
=================================

# key_controller

Memory-mapped pushbutton device on the shared processor data bus, peer to the 7-segment display device at 0xF000_0000. Synchronizes and debounces the four active-low board keys, exposes the debounced pressed state at a data register, and reports state changes through a sticky Ready/Overrun status register with an optional level interrupt. It is the input stage of the key-to-display path: software polls or takes an interrupt, reads the keys, and writes the result to the display device.

## Interface
- DBITS, 32, bus data/address width
- DATA_ADDR, 32'hF000_0010, KDATA address (read-only)
- CTRL_ADDR, 32'hF000_0110, KCTRL address (read/write)
- DEBOUNCE_CYCLES, 500000, cycles a raw change must persist (10 ms at 50 MHz); minimum 2
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low; one clock, reset asserted when low
- dbus  inout  DBITS  shared data bus; driven only during this device's reads, else high-Z
- address  input  DBITS  bus address
- wrtEn  input  1  1 = write cycle, 0 = read cycle
- KEY  input  4  raw board keys, active-low (0 = pressed), asynchronous to clk
- intr  output  1  interrupt request, level, active-high

## Operation
- Per key: 2-flop synchronizer on ~KEY[i] (pressed = 1), then debounce counter vs. stable bit.
- Debounce: synced == stable -> counter <= 0. synced != stable -> counter increments; when counter == DEBOUNCE_CYCLES-1, stable <= synced, counter <= 0. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Change event: any bit of stable[3:0] toggles this cycle (registered compare of stable vs. its previous value).
- KDATA read: {zeros, stable[3:0]}. A read of KDATA at a clock edge clears Ready. Writes to DATA_ADDR ignored.
- KCTRL layout: bit0 Ready (RO, sticky), bit2 Overrun (write 0 clears, write 1 ignored), bit8 IE (RW); other bits read 0, writes ignored.
- Change event: Ready <= 1; if Ready already 1, Overrun <= 1.
- Simultaneous change event and KDATA read: Ready stays 1, Overrun not set.
- Simultaneous change event with Ready=1 and KCTRL write clearing Overrun: Overrun ends 1 (set wins).
- intr = Ready & IE, from flops only.
- Read decode: address == DATA_ADDR or CTRL_ADDR with wrtEn == 0 drives dbus combinationally; write decode: address == CTRL_ADDR with wrtEn == 1, committed at clock edge.

## Timing
- Reset values: sync flops 0 (released), stable 0, counters 0, Ready 0, Overrun 0, IE 0, intr 0, dbus high-Z.
- Reset mid-debounce discards partial count; a key held through reset is reported as a change event DEBOUNCE_CYCLES+3 cycles after release of reset.
- Press-to-stable latency: 2 sync cycles + DEBOUNCE_CYCLES cycles; Ready/intr rise 1 cycle later.
- Read data valid combinationally in the same cycle as address; Ready clear visible the cycle after the read edge.
- A multi-cycle KDATA read clears Ready on every edge it spans.
- KCTRL write visible on read and intr the cycle after the write edge.

## Structure
- Shared package key_pkg: DATA_ADDR/CTRL_ADDR defaults, KCTRL bit indices (READY_BIT=0, OVR_BIT=2, IE_BIT=8), key count (4).
- Sub-module key_debouncer (synchronizer + counter + stable bit, parameter DEBOUNCE_CYCLES), instantiated 4 times via generate; bus decode, status and interrupt logic in key_controller.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4.)
- Reset low with KEY=4'b0000 -> dbus Z, intr 0; release reset, hold keys -> stable=4'hF after 7 cycles, Ready=1; KDATA read returns 0x0000000F.
- KEY[0] low for 3 cycles then high -> stable unchanged, Ready stays 0; low for 6 cycles -> KDATA=0x1, Ready=1.
- IE written 1 via KCTRL (0x100), press KEY[1] -> intr rises 1 cycle after stable change; KDATA read -> intr falls next cycle; KCTRL reads 0x100.
- Two debounced changes without a read -> KCTRL reads 0x5; write 0x100 -> reads 0x101; read KDATA -> 0x100.
- KDATA read on the same edge as a change event -> Ready remains 1, Overrun remains 0.
- Assert reset mid-debounce and mid-read -> all status 0, dbus Z immediately, no change event until a full debounce completes.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared constants and status layout for the pushbutton device.
// Bus addresses, KCTRL bit positions and the status word packer.
package key_pkg;

  localparam int KEY_DBITS = 32;
  localparam int NKEYS     = 4;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0110;

  localparam int READY_BIT = 0;
  localparam int OVR_BIT   = 2;
  localparam int IE_BIT    = 8;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } kstat_t;

  function automatic logic [KEY_DBITS-1:0] kctrl_word(
    input kstat_t s
  );
    logic [KEY_DBITS-1:0] w;
    w            = '0;
    w[READY_BIT] = s.ready;
    w[OVR_BIT]   = s.ovr;
    w[IE_BIT]    = s.ie;
    return w;
  endfunction

endpackage

// File: rtl/key_bus_if.sv
// key_bus_if: address/direction half of the shared processor bus.
// The data lines stay a plain inout net on the device.
interface key_bus_if #(
  parameter int DBITS = 32
);

  logic [DBITS-1:0] address;
  logic             wrtEn;

  modport master (
    output address,
    output wrtEn
  );

  modport slave (
    input address,
    input wrtEn
  );

endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchronizer plus persistence counter for one
// active-low key; stable_o is the debounced pressed state.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], ~key_n};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_controller.sv
// key_controller: debounced pushbutton device on the shared data bus
// with sticky Ready/Overrun status and a level interrupt.
module key_controller
  import key_pkg::*;
#(
  parameter int               DBITS           = KEY_DBITS,
  parameter logic [DBITS-1:0] DATA_ADDR       = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0] CTRL_ADDR       = DBITS'(DEF_CTRL_ADDR),
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DBITS-1:0] dbus,
  key_bus_if.slave         bus,
  input  logic [NKEYS-1:0] KEY,
  output logic             intr
);

  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] prev_q, prev_d;
  kstat_t           stat_q, stat_d;
  logic             change;
  logic             rd_data, rd_ctrl, wr_ctrl;
  logic [DBITS-1:0] rd_word;
  logic             unused_dbus;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dbn (
      .clk     (clk),
      .reset   (reset),
      .key_n   (KEY[i]),
      .stable_o(stable[i])
    );
  end

  assign rd_data = (bus.address == DATA_ADDR) && !bus.wrtEn;
  assign rd_ctrl = (bus.address == CTRL_ADDR) && !bus.wrtEn;
  assign wr_ctrl = (bus.address == CTRL_ADDR) && bus.wrtEn;

  assign change = |(stable ^ prev_q);

  // A read on the same edge as a change consumes the old data, so the
  // new change neither drops Ready nor counts as an overrun.
  always_comb begin
    prev_d = stable;
    stat_d = stat_q;
    if (change) begin
      stat_d.ready = 1'b1;
    end else if (rd_data) begin
      stat_d.ready = 1'b0;
    end
    if (change && stat_q.ready && !rd_data) begin
      stat_d.ovr = 1'b1;
    end else if (wr_ctrl && !dbus[OVR_BIT]) begin
      stat_d.ovr = 1'b0;
    end
    if (wr_ctrl) begin
      stat_d.ie = dbus[IE_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      stat_q <= '0;
    end else begin
      prev_q <= prev_d;
      stat_q <= stat_d;
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      rd_data: rd_word = {{(DBITS-NKEYS){1'b0}}, stable};
      rd_ctrl: rd_word = DBITS'(kctrl_word(stat_q));
      default: rd_word = '0;
    endcase
  end

  assign dbus = (reset && (rd_data || rd_ctrl)) ? rd_word : 'z;

  assign unused_dbus = ^dbus;

  assign intr = stat_q.ready & stat_q.ie;

endmodule

// File: tb/tb_key_controller.sv
// tb_key_controller: random bus/key traffic against a windowed debounce
// model; a monitor pops per-cycle expectations and compares.
`timescale 1ns/1ps
module tb_key_controller;

  localparam int D = 4;
  localparam logic [31:0] A_DATA = 32'hF000_0010;
  localparam logic [31:0] A_CTRL = 32'hF000_0110;
  localparam logic [31:0] A_DISP = 32'hF000_0000;

  typedef enum int {
    OP_IDLE, OP_RD_DATA, OP_RD_CTRL, OP_WR_CTRL, OP_WR_DATA
  } op_e;

  typedef struct {
    bit        rd;
    bit        rel;
    bit [31:0] bus;
    bit        intr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic        intr;
  tri1  [31:0] dbus;
  logic        tb_drive;
  logic [31:0] tb_wdata;

  key_bus_if bus ();

  assign dbus = tb_drive ? tb_wdata : 'z;

  key_controller #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .dbus   (dbus),
    .bus    (bus),
    .KEY    (KEY),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sbq[$];

  // Reference model state
  bit [3:0] hist[$];
  bit [3:0] m_stable, m_prev;
  bit       m_ready, m_ovr, m_ie;

  op_e        cur_op;
  logic [3:0] cur_key_n;
  logic [31:0] cur_wdata;
  logic       cur_rst_n;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back(4'b0000);
    m_stable = '0;
    m_prev   = '0;
    m_ready  = 1'b0;
    m_ovr    = 1'b0;
    m_ie     = 1'b0;
  endfunction

  // A key's debounced value flips once its pressed level, seen two
  // samples late, has disagreed with it for D consecutive samples.
  function automatic bit [3:0] next_stable();
    bit [3:0] ns;
    ns = m_stable;
    for (int i = 0; i < 4; i++) begin
      bit flip;
      flip = 1'b1;
      for (int k = 0; k < D; k++) begin
        if (hist[hist.size() - 3 - k][i] == m_stable[i]) flip = 1'b0;
      end
      if (flip) ns[i] = ~m_stable[i];
    end
    return ns;
  endfunction

  function automatic void model_edge(input op_e op, input logic [3:0] key_n,
                                     input logic [31:0] wdata);
    bit ev, rdd, wrc;
    bit [3:0] ns;
    hist.push_back(~key_n);
    if (hist.size() > D + 4) void'(hist.pop_front());
    ev  = (m_stable != m_prev);
    rdd = (op == OP_RD_DATA);
    wrc = (op == OP_WR_CTRL);
    if (ev && m_ready && !rdd) m_ovr = 1'b1;
    else if (wrc && !wdata[2]) m_ovr = 1'b0;
    if (ev) m_ready = 1'b1;
    else if (rdd) m_ready = 1'b0;
    if (wrc) m_ie = wdata[8];
    ns = next_stable();
    m_prev   = m_stable;
    m_stable = ns;
  endfunction

  task automatic cyc(input op_e op, input logic [3:0] key_n,
                     input logic [31:0] wdata, input logic rst_n);
    exp_t e;
    @(posedge clk);
    if (cur_rst_n) model_edge(cur_op, cur_key_n, cur_wdata);
    #1;
    reset    = rst_n;
    KEY      = key_n;
    tb_drive = 1'b0;
    tb_wdata = wdata;
    case (op)
      OP_RD_DATA: begin bus.address = A_DATA; bus.wrtEn = 1'b0; end
      OP_RD_CTRL: begin bus.address = A_CTRL; bus.wrtEn = 1'b0; end
      OP_WR_CTRL: begin
        bus.address = A_CTRL; bus.wrtEn = 1'b1; tb_drive = 1'b1;
      end
      OP_WR_DATA: begin
        bus.address = A_DATA; bus.wrtEn = 1'b1; tb_drive = 1'b1;
      end
      default: begin
        bus.address = ($urandom_range(0, 1) == 0) ? A_DISP : 32'h0000_1234;
        bus.wrtEn   = 1'b0;
      end
    endcase
    if (!rst_n) model_reset();
    cur_op    = op;
    cur_key_n = key_n;
    cur_wdata = wdata;
    cur_rst_n = rst_n;
    e.rd   = rst_n && (op == OP_RD_DATA || op == OP_RD_CTRL);
    e.rel  = !e.rd && op != OP_WR_CTRL && op != OP_WR_DATA;
    e.bus  = '1;
    if (e.rd && op == OP_RD_DATA) e.bus = {28'b0, m_stable};
    if (e.rd && op == OP_RD_CTRL)
      e.bus = {23'b0, m_ie, 5'b0, m_ovr, 1'b0, m_ready};
    e.intr = m_ready & m_ie;
    sbq.push_back(e);
  endtask

  task automatic hold(input int n, input op_e op, input logic [3:0] key_n);
    for (int i = 0; i < n; i++) cyc(op, key_n, 32'h0, 1'b1);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("intr", {31'b0, intr}, {31'b0, e.intr});
        if (e.rd) check("read_data", dbus, e.bus);
        else if (e.rel) check("dbus_released", dbus, 32'hFFFF_FFFF);
      end
    end
  end

  initial begin
    int       hcnt[4];
    logic [3:0] lvl;
    reset       = 1'b0;
    KEY         = 4'b0000;
    tb_drive    = 1'b0;
    tb_wdata    = '0;
    bus.address = A_DISP;
    bus.wrtEn   = 1'b0;
    cur_op      = OP_IDLE;
    cur_key_n   = 4'b0000;
    cur_wdata   = '0;
    cur_rst_n   = 1'b0;
    model_reset();

    // keys held through reset, read attempted during reset
    cyc(OP_RD_DATA, 4'b0000, 0, 1'b0);
    cyc(OP_RD_CTRL, 4'b0000, 0, 1'b0);
    hold(8, OP_IDLE, 4'b0000);
    cyc(OP_RD_CTRL, 4'b0000, 0, 1'b1);
    cyc(OP_RD_DATA, 4'b0000, 0, 1'b1);
    hold(10, OP_IDLE, 4'b1111);
    cyc(OP_RD_DATA, 4'b1111, 0, 1'b1);
    cyc(OP_WR_CTRL, 4'b1111, 32'h0, 1'b1);

    // glitch, then a real press of KEY[0]
    hold(3, OP_IDLE, 4'b1110);
    hold(6, OP_IDLE, 4'b1111);
    cyc(OP_RD_CTRL, 4'b1111, 0, 1'b1);
    hold(6, OP_IDLE, 4'b1110);
    hold(2, OP_RD_DATA, 4'b1110);
    cyc(OP_RD_CTRL, 4'b1110, 0, 1'b1);

    // interrupt enable, press KEY[1]
    cyc(OP_WR_CTRL, 4'b1110, 32'h0000_0100, 1'b1);
    hold(9, OP_IDLE, 4'b1100);
    cyc(OP_RD_DATA, 4'b1100, 0, 1'b1);
    hold(2, OP_RD_CTRL, 4'b1100);

    // two changes without a read, then clear overrun
    hold(8, OP_IDLE, 4'b1101);
    hold(8, OP_IDLE, 4'b1111);
    cyc(OP_RD_CTRL, 4'b1111, 0, 1'b1);
    cyc(OP_WR_CTRL, 4'b1111, 32'h0000_0100, 1'b1);
    cyc(OP_RD_CTRL, 4'b1111, 0, 1'b1);
    cyc(OP_RD_DATA, 4'b1111, 0, 1'b1);
    cyc(OP_RD_CTRL, 4'b1111, 0, 1'b1);
    cyc(OP_WR_DATA, 4'b1111, 32'hFFFF_FFFF, 1'b1);

    // multi-cycle KDATA read spanning a change event
    hold(12, OP_RD_DATA, 4'b1011);
    cyc(OP_RD_CTRL, 4'b1011, 0, 1'b1);

    // reset mid-debounce and mid-read
    hold(3, OP_IDLE, 4'b0011);
    cyc(OP_RD_DATA, 4'b0011, 0, 1'b0);
    cyc(OP_RD_DATA, 4'b0011, 0, 1'b0);
    hold(4, OP_RD_CTRL, 4'b0011);
    hold(6, OP_RD_CTRL, 4'b0011);

    // randomized traffic
    lvl = 4'b1111;
    for (int i = 0; i < 4; i++) hcnt[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      op_e op;
      logic [31:0] wd;
      for (int i = 0; i < 4; i++) begin
        if (hcnt[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          hcnt[i] = $urandom_range(1, 9);
        end
        hcnt[i]--;
      end
      r  = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 55)      op = OP_IDLE;
      else if (r < 70) op = OP_RD_DATA;
      else if (r < 82) op = OP_RD_CTRL;
      else if (r < 95) op = OP_WR_CTRL;
      else             op = OP_WR_DATA;
      if ($urandom_range(0, 599) == 0) begin
        cyc(OP_RD_DATA, lvl, 0, 1'b0);
        cyc(OP_RD_CTRL, lvl, 0, 1'b0);
      end else begin
        cyc(op, lvl, wd, 1'b1);
      end
    end

    hold(2, OP_IDLE, lvl);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
